log_taylor: RTL
===============

# log_taylor

Iterative IEEE-754 single-precision natural-logarithm unit, the inverse companion of the Taylor-series exponential datapath. It splits the operand into exponent and mantissa and evaluates ln(1+f) as a fixed-point Horner polynomial, one multiply-accumulate per clock. It then adds e·ln2 and repacks the result to single precision. It sits beside the exponential unit and uses the same start/done handshake style toward the controlling FSM.

## Interface
- `N`, 24: number of series terms; legal range 2..32.
- `clk` input 1: clock; all state changes on the rising edge.
- `res` input 1: synchronous, active-high reset.
- `start` input 1: request. Sampled only when `busy`=0.
- `num` input 32: IEEE-754 single operand. Captured in the cycle `start` is accepted.
- `lg` output 32: ln(`num`) in IEEE-754 single. Held from `done` until the next `done`.
- `busy` output 1: high while a computation is in flight.
- `done` output 1: one-cycle pulse. `lg` is valid in that same cycle.

## Operation
- Reset: `lg`=0x00000000, `busy`=0, `done`=0, state IDLE, all datapath registers cleared.
- A reset in any state aborts the operation. No `done` follows.
- States: IDLE → HORNER → FINAL → PACK → IDLE.
  - A special operand goes IDLE → PACK directly.
- Operand decode in IDLE when `start` is accepted:
  - `num` exponent field = 0 (zero or denormal): flush to zero, result 0xFF800000 (−inf).
  - Sign = 1 and not NaN: result 0x7FC00000.
  - NaN: result 0x7FC00000.
  - +inf: result 0x7F800000.
  - Otherwise `e` = exp−127 and `m` = 1.frac.
    - If frac[22]=1 (m ≥ 1.5): use m/2 and e+1, so `f` ∈ [−0.25, 0).
    - Else `f` = m−1 ∈ [0, 0.5).
- Number formats:
  - `f` and `acc`: signed Q1.30, 32 bits.
  - Products: signed 32×32 → 64 bits, arithmetic shift right by 30, truncated.
- Horner recurrence:
  - Load `acc` = C[N].
  - HORNER runs k = N−1 down to 1, one step per cycle: `acc` = C[k] − f·acc.
  - FINAL computes `fx` = e·LN2 + f·acc, where `fx` is signed Q8.30, 40 bits.
- PACK:
  - `fx` = 0 gives +0.
  - Otherwise sign = `fx`[39] and magnitude = |fx|.
  - p = index of the leading one. Biased exponent = 127 + p − 30.
  - Mantissa = the 23 bits below p, truncated; zero-filled if p < 23.
- PACK registers `lg` and asserts `done` for the next cycle.
- Accuracy: |lg − ln(num)| ≤ max(2^-26, 4 ulp of the true result).

## Timing
- Cycle 0: `start`=1 with `busy`=0. `num` is captured at the end of cycle 0.
- Normal operand:
  - `busy`=1 in cycles 1..N+1.
  - HORNER occupies cycles 1..N−1, FINAL cycle N, PACK cycle N+1.
  - `done`=1 and the new `lg` appear in cycle N+2 (cycle 26 for N=24).
- Special operand: `busy`=1 in cycle 1 only (PACK). `done`=1 in cycle 2.
- `start` while `busy`=1 is ignored: no capture, no queueing.
- A `start` in the `done` cycle is accepted, because the state is already IDLE. Back-to-back throughput is one result per N+2 cycles.
- `busy` and `done` are never high together.

## Structure
- Package `log_taylor_pkg` holds:
  - `LN2_Q30` = 744261118.
  - Coefficient ROM C[k] = round(2^30/k) for k = 1..32.
  - State enum.
  - Special constants: NEG_INF 0xFF800000, POS_INF 0x7F800000, QNAN 0x7FC00000.
- Sub-module `lzc40`: combinational leading-one detector over 40 bits. It returns p and a zero flag and is used in PACK.
- Single multiplier, time-shared between the HORNER and FINAL steps.

## Test plan
- `num`=0x3F800000 (1.0), N=24 → `lg`=0x00000000, `done` in cycle 26, `busy` high in cycles 1..25.
- `num`=0x40000000 (2.0) → 0x3F317218 ±2 ulp. `num`=0x3F000000 (0.5) → 0xBF317218 ±2 ulp. `num`=0x402DF854 (e) → 0x3F800000 ±4 ulp.
- `num`=0x3FC00000 (1.5, exercises the m/2 path) → 0x3ECF991F ±4 ulp. `num`=0x7F7FFFFF → 0x42B17218 ±4 ulp.
- Specials:
  - 0x00000000 → 0xFF800000.
  - 0x00000001 (denormal) → 0xFF800000.
  - 0xBF800000 → 0x7FC00000.
  - 0x7F800000 → 0x7F800000.
  - 0x7FC00001 → 0x7FC00000.
  - Each with `done` in cycle 2.
- `start` pulsed in cycle 5 during a busy operation with a different `num` → ignored, first result unchanged. A new `start` in the `done` cycle → accepted, second `done` N+2 cycles later.
- `res` asserted in cycle 10 of an operation → next cycle `busy`=0, `done`=0, `lg`=0, no `done` ever pulses. A subsequent `start` with 2.0 → correct result.

Source files
------------

// File: rtl/log_taylor_pkg.sv
// Shared constants, FSM encoding and coefficient ROM for the iterative
// single-precision natural-logarithm unit.
package log_taylor_pkg;

  localparam logic [31:0] LN2_Q30 = 32'd744261118;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HORNER = 2'd1,
    S_FINAL  = 2'd2,
    S_PACK   = 2'd3
  } state_e;

  // Entry k holds round(2^30 / k) in Q1.30; entry 0 is unused.
  typedef logic [32:0][31:0] coef_rom_t;

  function automatic coef_rom_t build_coef_rom();
    coef_rom_t rom;
    rom = '0;
    for (int k = 1; k <= 32; k++) begin
      rom[k] = 32'(((64'd1 << 30) + 64'(k / 2)) / 64'(k));
    end
    return rom;
  endfunction

  localparam coef_rom_t C_ROM = build_coef_rom();

endpackage

// File: rtl/log_taylor_lzc40.sv
// Leading-one detector over a 40-bit magnitude: returns the index of the
// highest set bit and a flag for an all-zero input.
module lzc40 (
  input  logic [39:0] v,
  output logic [5:0]  p,
  output logic        zero
);

  always_comb begin
    p = '0;
    for (int i = 0; i < 40; i++) begin
      if (v[i]) p = 6'(i);
    end
    zero = (v == '0);
  end

endmodule

// File: rtl/log_taylor.sv
// ln(num) for IEEE-754 single: range-reduce to e and f, evaluate ln(1+f) by
// Horner with one shared multiply per clock, add e*ln2, repack to single.
module log_taylor
  import log_taylor_pkg::*;
#(
  parameter int N = 24  // series terms, 2..32
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic [31:0] num,
  output logic [31:0] lg,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  // Handshake: start is sampled only while busy=0 (IDLE, including the done
  // cycle); done is a one-cycle pulse with lg valid, and never overlaps busy.

  state_e             state_q, state_d;
  logic signed [31:0] f_q, f_d;
  logic signed [31:0] acc_q, acc_d;
  logic signed [8:0]  e_q, e_d;
  logic [5:0]         k_q, k_d;
  logic signed [39:0] fx_q, fx_d;
  logic               special_q, special_d;
  logic [31:0]        spec_val_q, spec_val_d;
  logic [31:0]        lg_q, lg_d;
  logic               done_q, done_d;

  logic [7:0]  num_exp;
  logic [22:0] num_frac;
  logic        dec_special;
  logic [31:0] dec_val;
  logic [31:0] dec_f;
  logic [8:0]  dec_e;

  assign num_exp  = num[30:23];
  assign num_frac = num[22:0];

  always_comb begin
    dec_special = 1'b1;
    dec_val     = QNAN;
    dec_f       = '0;
    dec_e       = '0;
    if (num_exp == 8'h00) begin
      dec_val = NEG_INF;
    end else if (num_exp == 8'hFF && num_frac != '0) begin
      dec_val = QNAN;
    end else if (num[31]) begin
      dec_val = QNAN;
    end else if (num_exp == 8'hFF) begin
      dec_val = POS_INF;
    end else begin
      dec_special = 1'b0;
      // Mantissas >= 1.5 are halved so f stays in [-0.25, 0.5).
      if (num_frac[22]) begin
        dec_f = {3'b001, num_frac, 6'b0} - 32'h4000_0000;
        dec_e = {1'b0, num_exp} - 9'd126;
      end else begin
        dec_f = {2'b00, num_frac, 7'b0};
        dec_e = {1'b0, num_exp} - 9'd127;
      end
    end
  end

  logic signed [63:0] prod;
  logic signed [63:0] prod_sh;
  logic signed [39:0] e_ext;
  logic signed [39:0] e_ln2;

  assign prod    = f_q * acc_q;
  assign prod_sh = prod >>> 30;
  assign e_ext   = {{31{e_q[8]}}, e_q};
  assign e_ln2   = e_ext * $signed({8'd0, LN2_Q30});

  logic [39:0] mag;
  logic [39:0] mag_norm;
  logic [5:0]  lead_pos;
  logic        mag_zero;
  logic [31:0] packed_val;

  assign mag = fx_q[39] ? (40'd0 - fx_q) : fx_q;

  lzc40 u_lzc (
    .v    (mag),
    .p    (lead_pos),
    .zero (mag_zero)
  );

  // Left-justify the leading one at bit 39 so the 23 bits below it sit at
  // [38:16]; short magnitudes are zero-filled by the shift.
  assign mag_norm   = mag << (6'd39 - lead_pos);
  assign packed_val = mag_zero ? 32'h0000_0000
                               : {fx_q[39], {2'b00, lead_pos} + 8'd97, mag_norm[38:16]};

  always_comb begin
    state_d    = state_q;
    f_d        = f_q;
    acc_d      = acc_q;
    e_d        = e_q;
    k_d        = k_q;
    fx_d       = fx_q;
    special_d  = special_q;
    spec_val_d = spec_val_q;
    lg_d       = lg_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          special_d  = dec_special;
          spec_val_d = dec_val;
          if (dec_special) begin
            state_d = S_PACK;
          end else begin
            f_d     = dec_f;
            e_d     = dec_e;
            acc_d   = C_ROM[N];
            k_d     = 6'(N - 1);
            state_d = S_HORNER;
          end
        end
      end
      S_HORNER: begin
        acc_d = C_ROM[k_q] - prod_sh[31:0];
        if (k_q == 6'd1) state_d = S_FINAL;
        else             k_d     = k_q - 6'd1;
      end
      S_FINAL: begin
        fx_d    = e_ln2 + prod_sh[39:0];
        state_d = S_PACK;
      end
      S_PACK: begin
        lg_d    = special_q ? spec_val_q : packed_val;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= S_IDLE;
      f_q        <= '0;
      acc_q      <= '0;
      e_q        <= '0;
      k_q        <= '0;
      fx_q       <= '0;
      special_q  <= 1'b0;
      spec_val_q <= '0;
      lg_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_q        <= f_d;
      acc_q      <= acc_d;
      e_q        <= e_d;
      k_q        <= k_d;
      fx_q       <= fx_d;
      special_q  <= special_d;
      spec_val_q <= spec_val_d;
      lg_q       <= lg_d;
      done_q     <= done_d;
    end
  end

  assign lg        = lg_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule
